miller_frame_assembler: RTL

//  Consumes the decoded bit stream of the Miller decoder (form_valid/form_data and its sticky error flags) and

---
 rtl/miller_frame_assembler_if.sv | 27 ++
 rtl/miller_frame_assembler.sv | 109 ++++++++++
 2 files changed

// File: rtl/miller_frame_assembler_if.sv
// miller_frame_assembler_if: arm/config, decoded-bit stream and byte/status result bundle
interface miller_frame_assembler_if #(
    parameter int LEN_W = 10
);
    logic             arm_i;
    logic             crc_en_i;
    logic [LEN_W-1:0] expected_bits_i;
    logic             form_valid_i;
    logic             form_data_i;
    logic             err_form_i;
    logic             err_lost_i;
    logic             byte_valid_o;
    logic [7:0]       byte_data_o;
    logic             busy_o;
    logic             frame_done_o;
    logic [LEN_W-1:0] frame_len_o;
    logic             crc_ok_o;
    logic [2:0]       err_code_o;
    modport slave (
        input  arm_i, crc_en_i, expected_bits_i, form_valid_i, form_data_i, err_form_i, err_lost_i,
        output byte_valid_o, byte_data_o, busy_o, frame_done_o, frame_len_o, crc_ok_o, err_code_o
    );
    modport master (
        output arm_i, crc_en_i, expected_bits_i, form_valid_i, form_data_i, err_form_i, err_lost_i,
        input  byte_valid_o, byte_data_o, busy_o, frame_done_o, frame_len_o, crc_ok_o, err_code_o
    );
endinterface

// File: rtl/miller_frame_assembler.sv
// miller_frame_assembler: packs decoded Miller bits into bytes, checks dummy bit and CRC-16, reports frame status
module miller_frame_assembler #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int LEN_W       = 10
) (
    input logic clk_i,
    input logic rst_i,
    miller_frame_assembler_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, WAIT_FIRST, RECV, DONE} state_t;
    state_t           state_q;
    logic [LEN_W-1:0] exp_q, len_q, frame_len_q;
    logic             crc_en_q, form_q, lost_q;
    logic [6:0]       sr_q;
    logic [2:0]       bc_q, err_q;
    logic [15:0]      crc_q, crc_d;
    logic [TW-1:0]    tmo_q;
    logic             byte_valid_q, busy_q, done_q, crc_ok_q;
    logic [7:0]       byte_q, nb_d, flush_d;
    logic             form_edge, lost_edge, tmo_hit, dummy_bit, last_bit, crc_match, fin_d;
    logic [2:0]       err_d;
    // error-edge detection, byte/CRC next values and the frame-finish decision with error priority
    always_comb begin
        form_edge = bus.err_form_i & ~form_q;
        lost_edge = bus.err_lost_i & ~lost_q;
        tmo_hit   = !bus.form_valid_i && tmo_q == TW'(TIMEOUT_CYC - 1);
        dummy_bit = len_q == exp_q;
        last_bit  = LEN_W'(len_q + 1'b1) == exp_q;
        nb_d      = {sr_q, bus.form_data_i};
        flush_d   = nb_d << (3'd7 - bc_q);
        crc_d     = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bus.form_data_i) ? 16'h1021 : 16'h0000);
        crc_match = crc_q == 16'h1D0F;
        fin_d     = form_edge || lost_edge || tmo_hit || (bus.form_valid_i && dummy_bit);
        err_d     = form_edge ? 3'd1 : lost_edge ? 3'd2 : tmo_hit ? 3'd3 :
                    !bus.form_data_i ? 3'd4 : (crc_en_q && !crc_match) ? 3'd5 : 3'd0;
    end
    // frame FSM; arm restarts capture from any state and outranks every same-cycle event
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            len_q        <= '0;
            frame_len_q  <= '0;
            crc_en_q     <= 1'b0;
            form_q       <= 1'b0;
            lost_q       <= 1'b0;
            sr_q         <= '0;
            bc_q         <= '0;
            err_q        <= '0;
            crc_q        <= 16'hFFFF;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
        end else begin
            form_q       <= bus.err_form_i;
            lost_q       <= bus.err_lost_i;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (bus.arm_i) begin
                state_q  <= WAIT_FIRST;
                exp_q    <= bus.expected_bits_i == '0 ? LEN_W'(1) : bus.expected_bits_i;
                crc_en_q <= bus.crc_en_i;
                len_q    <= '0;
                sr_q     <= '0;
                bc_q     <= '0;
                crc_q    <= 16'hFFFF;
                tmo_q    <= '0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    DONE: state_q <= IDLE;
                    WAIT_FIRST, RECV: begin
                        tmo_q <= bus.form_valid_i ? '0 : tmo_q + 1'b1;
                        if (fin_d) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            frame_len_q <= len_q;
                            crc_ok_q    <= ~crc_en_q | crc_match;
                            err_q       <= err_d;
                        end else if (bus.form_valid_i) begin
                            state_q <= RECV;
                            sr_q    <= nb_d[6:0];
                            bc_q    <= bc_q + 3'd1;
                            len_q   <= len_q + 1'b1;
                            crc_q   <= crc_d;
                            if (bc_q == 3'd7 || last_bit) begin
                                byte_valid_q <= 1'b1;
                                byte_q       <= flush_d;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign bus.byte_valid_o = byte_valid_q;
    assign bus.byte_data_o  = byte_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = done_q;
    assign bus.frame_len_o  = frame_len_q;
    assign bus.crc_ok_o     = crc_ok_q;
    assign bus.err_code_o   = err_q;
endmodule
